ysyx_23060203_lsu: RTL
======================

# ysyx_23060203_lsu

Load/store stage of the ysyx_23060203 pipeline, sitting between EXU (upstream) and WBU (downstream). It accepts one instruction at a time from EXU. Loads and stores go out on an AXI4-Lite master port; loaded data is extended and merged into the writeback bundle. All other instructions pass through as a one-cycle register stage. Instructions that flush the pipeline serialise the stage until `flush` returns from the control-flow unit.

## Interface
- Parameters: none; address and data are fixed at 32 bits.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: EXU handshake; transfer when both are high.
- `in_pc`  in  32  instruction PC.
- `in_mem_ren`, `in_mem_wen`  in  1 each  load / store (never both high).
- `in_mem_func`  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `in_addr`  in  32  effective address.
- `in_wdata`  in  32  store data (rs2).
- `in_gpr_waddr` in 5, `in_gpr_wdata` in 32: destination and non-load result.
- `in_csr_wen` in 1, `in_csr_waddr` in 12, `in_csr_wdata` in 32, `in_exc`/`in_ret`/`in_fencei` in 1 each: passed through unchanged.
- `out_valid` out 1 / `out_ready` in 1: WBU handshake.
- `out_pc`, `out_gpr_waddr`, `out_gpr_wdata`, `out_csr_wen`, `out_csr_waddr`, `out_csr_wdata`, `out_exc`, `out_ret`, `out_fencei`  out: registered copies with the same widths as the inputs.
  - For loads, `out_gpr_wdata` carries the extended load data.
- `flush`  in  1  one-cycle pulse from the control-flow unit that discards younger work.
- `araddr` out 32, `arvalid` out 1, `arready` in 1.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1.
- `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- **States:** IDLE, RADDR, RDATA, WREQ, WRESP, DONE. Each accepted instruction's bundle is latched into internal registers.
- **Acceptance:** `in_ready` = !block & (IDLE | (DONE & out_ready)).
  - Load: go to RADDR. Store: go to WREQ. Otherwise: go to DONE.
- **RADDR:** `arvalid`=1, `araddr`=latched address. On `arready`, go to RDATA.
- **RDATA:** `rready`=1. On `rvalid`, capture and extend the data, then go to DONE.
- **WREQ:** `awvalid` and `wvalid` rise together. Each drops independently after its own handshake. When both are done, go to WRESP.
- **WRESP:** `bready`=1. On `bvalid`, go to DONE.
- **DONE:** `out_valid`=1. On `out_ready`, go to IDLE, or directly to the next state if a new instruction is accepted in the same cycle.
- **Load extraction** uses lane = addr[1:0]:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: halfword at addr[1]*16, sign- or zero-extended.
  - LW: whole word.
- **Store lanes:**
  - SB: `wstrb`=0001<<addr[1:0], `wdata`=byte replicated ×4.
  - SH: `wstrb`=0011<<(addr[1]*2), `wdata`=halfword replicated ×2.
  - SW: `wstrb`=1111.
  - `awaddr` is the full address.
- **Not checked in this revision:** misalignment is not detected, and `rresp`/`bresp` are ignored.
- **Serialisation:** accepting an instruction with csr_wen | exc | ret | fencei sets `block`. `block` clears only on `flush`.
- **flush** in DONE or IDLE: `out_valid` drops the next cycle and the state goes to IDLE.
- **flush** in RADDR/RDATA/WREQ/WRESP: the bus transaction completes (no valid is withdrawn before its handshake), the result is discarded, and the state goes to IDLE, not DONE.
- **flush and acceptance in the same cycle:** flush wins and nothing is accepted.

## Timing
- **Reset (asynchronous):** state=IDLE, block=0, and `out_valid`, `arvalid`, `awvalid`, `wvalid`, `rready`, `bready` all 0. `in_ready`=1 on the first cycle after release.
- **Pass-through:** accepted at N, `out_valid` at N+1. Throughput is 1/cycle while `out_ready`=1.
- **Load, zero-wait slave:** accept N, AR handshake N+1, R handshake N+2, `out_valid` N+3.
- **Store, zero-wait slave:** accept N, AW+W handshake N+1, B handshake N+2, `out_valid` N+3.
- All outputs are registered or decoded from state, with no combinational path from the bus to `out_*`.
- **Backpressure:** `out_*` are held stable while `out_valid` & !`out_ready`.
- **Bus stalls:** wait indefinitely in the current state.

## Test plan
- Reset mid-load (during RDATA) → all valid/ready outputs 0 immediately. After release, `in_ready`=1 and no stale `out_valid`.
- Back-to-back ALU instructions (pc 0x80000000, 0x80000004, wdata 5, 7) → `out_valid` on consecutive cycles with the matching pc and data.
- LB at 0x80001003, rdata=0x80FF1234 → `out_gpr_wdata`=0xFFFFFF80. LBU → 0x00000080. LH at 0x80001002 → 0xFFFF80FF. LW → 0x80FF1234.
- SH at 0x80001002, rs2=0x0000ABCD, with awready delayed 3 cycles and wready immediate → `wvalid` drops after 1 cycle, `awvalid` after 4; `wstrb`=1100, `wdata`=0xABCDABCD; `out_valid` one cycle after `bvalid`.
- CSR-write instruction, then an offered load → `in_ready`=0 until `flush`. Load accepted the cycle after `flush`.
- `flush` while in RADDR → `arvalid` held until `arready`, R is consumed, no `out_valid`, and the stage returns to IDLE.

Source files
------------

// File: rtl/ysyx_23060203_lsu.sv
// Load/store stage: issues AXI4-Lite reads and writes for memory instructions,
// and registers all other instructions straight through to writeback.
module ysyx_23060203_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [2:0]  in_mem_func,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_gpr_waddr,
  output logic [31:0] out_gpr_wdata,
  output logic        out_csr_wen,
  output logic [11:0] out_csr_waddr,
  output logic [31:0] out_csr_wdata,
  output logic        out_exc,
  output logic        out_ret,
  output logic        out_fencei,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t      state_p1, state_n, target;
  logic        block_p1, drop_p1, aw_done_p1, w_done_p1;
  logic        accept, serial, drop_now;
  logic [31:0] pc_p1, addr_p1, wdata_p1, gpr_wdata_p1, csr_wdata_p1;
  logic [2:0]  func_p1;
  logic [3:0]  wstrb_p1;
  logic [4:0]  gpr_waddr_p1;
  logic [11:0] csr_waddr_p1;
  logic        csr_wen_p1, exc_p1, ret_p1, fencei_p1;
  logic        unused_resp;

  function automatic logic [31:0] load_ext(input logic [2:0] func, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (func)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] func, input logic [1:0] lane);
    case (func)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] func, input logic [31:0] d);
    case (func)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // flush beats acceptance; in_ready is also forced low while reset is held
  assign in_ready = reset & !block_p1 & !flush &
                    ((state_p1 == IDLE) | ((state_p1 == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign serial   = in_csr_wen | in_exc | in_ret | in_fencei;
  assign drop_now = drop_p1 | flush;
  assign target   = in_mem_ren ? RADDR : (in_mem_wen ? WREQ : DONE);

  always_comb begin
    state_n = state_p1;
    case (state_p1)
      IDLE:    if (accept) state_n = target;
      RADDR:   if (arready) state_n = RDATA;
      RDATA:   if (rvalid) state_n = drop_now ? IDLE : DONE;
      WREQ:    if ((aw_done_p1 | awready) & (w_done_p1 | wready)) state_n = WRESP;
      WRESP:   if (bvalid) state_n = drop_now ? IDLE : DONE;
      DONE: begin
        if (flush)          state_n = IDLE;
        else if (out_ready) state_n = accept ? target : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // control stage: state, serialisation and flush bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p1   <= IDLE;
      block_p1   <= 1'b0;
      drop_p1    <= 1'b0;
      aw_done_p1 <= 1'b0;
      w_done_p1  <= 1'b0;
    end else begin
      state_p1 <= state_n;
      if (flush)               block_p1 <= 1'b0;
      else if (accept & serial) block_p1 <= 1'b1;
      if (state_n == IDLE || state_n == DONE) drop_p1 <= 1'b0;
      else if (flush)                         drop_p1 <= 1'b1;
      aw_done_p1 <= (state_p1 == WREQ) & (state_n == WREQ) & (aw_done_p1 | awready);
      w_done_p1  <= (state_p1 == WREQ) & (state_n == WREQ) & (w_done_p1 | wready);
    end
  end

  // data stage: instruction bundle, store lanes and extended load result
  always_ff @(posedge clock) begin
    if (accept) begin
      pc_p1        <= in_pc;
      addr_p1      <= in_addr;
      func_p1      <= in_mem_func;
      wstrb_p1     <= store_strb(in_mem_func[1:0], in_addr[1:0]);
      wdata_p1     <= store_data(in_mem_func[1:0], in_wdata);
      gpr_waddr_p1 <= in_gpr_waddr;
      gpr_wdata_p1 <= in_gpr_wdata;
      csr_wen_p1   <= in_csr_wen;
      csr_waddr_p1 <= in_csr_waddr;
      csr_wdata_p1 <= in_csr_wdata;
      exc_p1       <= in_exc;
      ret_p1       <= in_ret;
      fencei_p1    <= in_fencei;
    end else if (state_p1 == RDATA && rvalid) begin
      gpr_wdata_p1 <= load_ext(func_p1, addr_p1[1:0], rdata);
    end
  end

  assign out_valid     = (state_p1 == DONE);
  assign out_pc        = pc_p1;
  assign out_gpr_waddr = gpr_waddr_p1;
  assign out_gpr_wdata = gpr_wdata_p1;
  assign out_csr_wen   = csr_wen_p1;
  assign out_csr_waddr = csr_waddr_p1;
  assign out_csr_wdata = csr_wdata_p1;
  assign out_exc       = exc_p1;
  assign out_ret       = ret_p1;
  assign out_fencei    = fencei_p1;

  assign araddr  = addr_p1;
  assign arvalid = (state_p1 == RADDR);
  assign rready  = (state_p1 == RDATA);
  assign awaddr  = addr_p1;
  assign awvalid = (state_p1 == WREQ) & !aw_done_p1;
  assign wdata   = wdata_p1;
  assign wstrb   = wstrb_p1;
  assign wvalid  = (state_p1 == WREQ) & !w_done_p1;
  assign bready  = (state_p1 == WRESP);

  assign unused_resp = ^{rresp, bresp};

endmodule
